// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: widths, tag-table entry and request/response beat types for the L2 request arbiter.
package l2_arb_pkg;
    localparam int NUMREQ  = 4;
    localparam int BITADDR = 34;
    localparam int BITDATA = 512;
    localparam int BITSEQN = 16;
    localparam int XBITATR = 3;
    localparam int NUMTAGS = 16;
    localparam int BITTAGS = 4;
    localparam int BITOWNR = $clog2(NUMREQ);
    localparam int BITCNT  = BITTAGS + 1;

    typedef struct packed {
        logic [BITOWNR-1:0] owner;
        logic [BITSEQN-1:0] seq;
    } tagEntry_t;

    typedef struct packed {
        logic               rd;
        logic               wr;
        logic [BITSEQN-1:0] seq;
        logic [BITADDR-1:0] addr;
        logic [BITDATA-1:0] din;
    } reqBeat_t;

    typedef struct packed {
        logic [BITOWNR-1:0] owner;
        logic [BITSEQN-1:0] seq;
        logic [BITDATA-1:0] dout;
        logic [XBITATR-1:0] attr;
    } rspBeat_t;
endpackage

// File: rtl/l2_rr_arbiter.sv
// l2_rr_arbiter: one-hot round-robin grant searching from ptr; nextPtr points just past the winner.
module l2_rr_arbiter #(
    parameter  int NUMREQ = 4,
    localparam int BITPTR = $clog2(NUMREQ)
) (
    input  logic [NUMREQ-1:0] req,
    input  logic              en,
    input  logic [BITPTR-1:0] ptr,
    output logic [NUMREQ-1:0] grant,
    output logic [BITPTR-1:0] nextPtr
);
    logic found;
    int   idx;

    always_comb begin
        grant   = '0;
        nextPtr = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUMREQ; i++) begin
            idx = (int'(ptr) + i) % NUMREQ;
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                nextPtr    = BITPTR'((idx + 1) % NUMREQ);
            end
        end
    end
endmodule

// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: shares one L2 port among NUMREQ requesters round-robin, remapping
// sequence numbers to local tags so responses may return out of order.
module l2_req_arbiter
    import l2_arb_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUMREQ-1:0]           up_reqRd,
    input  logic [NUMREQ-1:0]           up_reqWr,
    input  logic [NUMREQ*BITSEQN-1:0]   up_reqSeq,
    input  logic [NUMREQ*BITADDR-1:0]   up_reqAddr,
    input  logic [NUMREQ*BITDATA-1:0]   up_reqDin,
    output logic [NUMREQ-1:0]           up_reqStall,
    output logic [NUMREQ-1:0]           up_rspVld,
    output logic [BITSEQN-1:0]          up_rspSeq,
    output logic [BITDATA-1:0]          up_rspDout,
    output logic [XBITATR-1:0]          up_rspAttr,
    input  logic [NUMREQ-1:0]           up_rspStall,
    output logic                        dn_reqRd,
    output logic                        dn_reqWr,
    output logic [BITSEQN-1:0]          dn_reqSeq,
    output logic [BITADDR-1:0]          dn_reqAddr,
    output logic [BITDATA-1:0]          dn_reqDin,
    input  logic                        dn_reqStall,
    input  logic                        dn_rspVld,
    input  logic [BITSEQN-1:0]          dn_rspSeq,
    input  logic [BITDATA-1:0]          dn_rspDout,
    input  logic [XBITATR-1:0]          dn_rspAttr,
    output logic                        dn_rspStall,
    output logic [BITTAGS:0]            numOutstanding,
    output logic                        errBadTag
);
    logic [NUMREQ-1:0]  pending, grant;
    logic [BITOWNR-1:0] rrPtr, rrPtrNext, winner;
    logic [NUMTAGS-1:0] freeMap, allocMask, freeMask;
    logic [BITTAGS-1:0] allocTag, rspTag;
    logic               reqLoad, alloc, reqVld;
    logic               rspVld, rspDrain, rspLoad, rspAccept, tagOk, tagFree;
    reqBeat_t           reqBeat;
    rspBeat_t           rspBeat;
    tagEntry_t          tagTable [NUMTAGS];

    assign pending = up_reqRd | up_reqWr;
    assign reqLoad = !reqVld || !dn_reqStall;

    l2_rr_arbiter #(.NUMREQ(NUMREQ)) uArb (
        .req     (pending),
        .en      (reqLoad && |freeMap),
        .ptr     (rrPtr),
        .grant   (grant),
        .nextPtr (rrPtrNext)
    );

    assign alloc       = |grant;
    assign up_reqStall = rst_n ? ~grant : '0;

    always_comb begin
        winner = '0;
        for (int i = NUMREQ - 1; i >= 0; i--)
            if (grant[i]) winner = BITOWNR'(i);
        allocTag = '0;
        for (int t = NUMTAGS - 1; t >= 0; t--)
            if (freeMap[t]) allocTag = BITTAGS'(t);
    end

    // A response is only taken when the stage can load, so an accepted beat always lands.
    assign rspDrain    = rspVld && !up_rspStall[rspBeat.owner];
    assign rspLoad     = !rspVld || rspDrain;
    assign dn_rspStall = !rspLoad;
    assign rspAccept   = dn_rspVld && rspLoad;
    assign rspTag      = dn_rspSeq[BITTAGS-1:0];
    assign tagOk       = ((dn_rspSeq >> BITTAGS) == '0) && !freeMap[rspTag];
    assign tagFree     = rspAccept && tagOk;
    assign allocMask   = alloc ? NUMTAGS'(1) << allocTag : '0;
    assign freeMask    = tagFree ? NUMTAGS'(1) << rspTag : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr          <= '0;
            freeMap        <= '1;
            numOutstanding <= '0;
            errBadTag      <= 1'b0;
            reqVld         <= 1'b0;
            reqBeat        <= '0;
            rspVld         <= 1'b0;
            rspBeat        <= '0;
        end else begin
            rrPtr          <= rrPtrNext;
            freeMap        <= (freeMap & ~allocMask) | freeMask;
            numOutstanding <= numOutstanding + BITCNT'(alloc) - BITCNT'(tagFree);
            if (rspAccept && !tagOk) errBadTag <= 1'b1;
            if (reqLoad) reqVld <= alloc;
            if (alloc)
                reqBeat <= '{rd:   up_reqRd[winner],
                             wr:   up_reqWr[winner] && !up_reqRd[winner],
                             seq:  BITSEQN'(allocTag),
                             addr: up_reqAddr[winner*BITADDR +: BITADDR],
                             din:  up_reqDin[winner*BITDATA +: BITDATA]};
            if (rspLoad) rspVld <= tagFree;
            if (tagFree)
                rspBeat <= '{owner: tagTable[rspTag].owner,
                             seq:   tagTable[rspTag].seq,
                             dout:  dn_rspDout,
                             attr:  dn_rspAttr};
        end
    end

    // Entries are only meaningful while their free bit is clear, so the table needs no reset.
    always_ff @(posedge clk)
        if (alloc) tagTable[allocTag] <= '{owner: winner, seq: up_reqSeq[winner*BITSEQN +: BITSEQN]};

    assign dn_reqRd   = reqVld && reqBeat.rd;
    assign dn_reqWr   = reqVld && reqBeat.wr;
    assign dn_reqSeq  = reqBeat.seq;
    assign dn_reqAddr = reqBeat.addr;
    assign dn_reqDin  = reqBeat.din;
    assign up_rspVld  = rspVld ? NUMREQ'(1) << rspBeat.owner : '0;
    assign up_rspSeq  = rspBeat.seq;
    assign up_rspDout = rspBeat.dout;
    assign up_rspAttr = rspBeat.attr;
endmodule

// File: tb/tb_l2_req_arbiter.sv
// tb_l2_req_arbiter: directed self-checking bench for l2_req_arbiter.
module tb_l2_req_arbiter;
    import l2_arb_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUMREQ-1:0]         up_reqRd, up_reqWr, up_reqStall, up_rspVld, up_rspStall;
    logic [NUMREQ*BITSEQN-1:0] up_reqSeq;
    logic [NUMREQ*BITADDR-1:0] up_reqAddr;
    logic [NUMREQ*BITDATA-1:0] up_reqDin;
    logic [BITSEQN-1:0]        up_rspSeq, dn_reqSeq, dn_rspSeq;
    logic [BITDATA-1:0]        up_rspDout, dn_reqDin, dn_rspDout;
    logic [XBITATR-1:0]        up_rspAttr, dn_rspAttr;
    logic                      dn_reqRd, dn_reqWr, dn_reqStall, dn_rspVld, dn_rspStall, errBadTag;
    logic [BITADDR-1:0]        dn_reqAddr;
    logic [BITTAGS:0]          numOutstanding;
    logic [NUMREQ-1:0]         exp4;
    int                        compared = 0;
    int                        mismatched = 0;

    always #5 clk = ~clk;

    l2_req_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .up_reqRd(up_reqRd), .up_reqWr(up_reqWr), .up_reqSeq(up_reqSeq),
        .up_reqAddr(up_reqAddr), .up_reqDin(up_reqDin), .up_reqStall(up_reqStall),
        .up_rspVld(up_rspVld), .up_rspSeq(up_rspSeq), .up_rspDout(up_rspDout),
        .up_rspAttr(up_rspAttr), .up_rspStall(up_rspStall),
        .dn_reqRd(dn_reqRd), .dn_reqWr(dn_reqWr), .dn_reqSeq(dn_reqSeq),
        .dn_reqAddr(dn_reqAddr), .dn_reqDin(dn_reqDin), .dn_reqStall(dn_reqStall),
        .dn_rspVld(dn_rspVld), .dn_rspSeq(dn_rspSeq), .dn_rspDout(dn_rspDout),
        .dn_rspAttr(dn_rspAttr), .dn_rspStall(dn_rspStall),
        .numOutstanding(numOutstanding), .errBadTag(errBadTag)
    );

    always @(negedge clk)
        if (rst_n) assert (!(|(up_reqRd & up_reqWr))) else $error("illegal simultaneous read and write request");

    task automatic chk(input string tag, input logic [BITDATA-1:0] obs, input logic [BITDATA-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int i, input logic [BITSEQN-1:0] s, input logic [BITADDR-1:0] a,
                          input logic [BITDATA-1:0] d);
        up_reqSeq[i*BITSEQN +: BITSEQN]  = s;
        up_reqAddr[i*BITADDR +: BITADDR] = a;
        up_reqDin[i*BITDATA +: BITDATA]  = d;
    endtask

    task automatic rsp(input logic [BITSEQN-1:0] tag, input logic [BITDATA-1:0] d, input logic [XBITATR-1:0] a);
        dn_rspVld  = 1'b1;
        dn_rspSeq  = tag;
        dn_rspDout = d;
        dn_rspAttr = a;
        tick();
        dn_rspVld = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        up_reqRd = '0; up_reqWr = '0; up_reqSeq = '0; up_reqAddr = '0; up_reqDin = '0;
        up_rspStall = '0; dn_reqStall = 1'b0; dn_rspVld = 1'b0; dn_rspSeq = '0;
        dn_rspDout = '0; dn_rspAttr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst reqStall", up_reqStall, 4'h0);
        chk("rst dnRd", dn_reqRd, 1'b0);
        chk("rst rspVld", up_rspVld, 4'h0);
        chk("rst dnRspStall", dn_rspStall, 1'b0);
        chk("rst outstanding", numOutstanding, 5'd0);
        chk("rst err", errBadTag, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("idle stall", up_reqStall, 4'hF);

        // round-robin over four continuous readers
        for (int i = 0; i < 4; i++) setReq(i, 16'h0100 + 16'(i), 34'h1000 + 34'(i * 64), '0);
        up_reqRd = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp4 = ~(4'b0001 << (k % 4));
            chk($sformatf("rr stall %0d", k), up_reqStall, exp4);
            tick();
            if (k == 4) up_reqRd = '0;
            #1;
            chk($sformatf("rr rd %0d", k), dn_reqRd, 1'b1);
            chk($sformatf("rr tag %0d", k), dn_reqSeq, 16'(k));
            chk($sformatf("rr addr %0d", k), dn_reqAddr, 34'h1000 + 34'((k % 4) * 64));
        end
        chk("rr outstanding", numOutstanding, 5'd5);

        // out-of-order responses 3,1,2 then 0,4
        rsp(16'd3, 512'h5003, 3'd3);
        chk("ooo3 vld", up_rspVld, 4'b1000);
        chk("ooo3 seq", up_rspSeq, 16'h0103);
        chk("ooo3 dout", up_rspDout, 512'h5003);
        chk("ooo3 attr", up_rspAttr, 3'd3);
        chk("ooo3 cnt", numOutstanding, 5'd4);
        rsp(16'd1, 512'h5001, 3'd1);
        chk("ooo1 vld", up_rspVld, 4'b0010);
        chk("ooo1 seq", up_rspSeq, 16'h0101);
        chk("ooo1 cnt", numOutstanding, 5'd3);
        rsp(16'd2, 512'h5002, 3'd2);
        chk("ooo2 vld", up_rspVld, 4'b0100);
        chk("ooo2 seq", up_rspSeq, 16'h0102);
        rsp(16'd0, 512'h5000, 3'd0);
        chk("ooo0 vld", up_rspVld, 4'b0001);
        rsp(16'd4, 512'h5004, 3'd4);
        chk("ooo4 vld", up_rspVld, 4'b0001);
        chk("ooo4 seq", up_rspSeq, 16'h0100);
        chk("ooo cnt", numOutstanding, 5'd0);
        tick();
        chk("ooo idle", up_rspVld, 4'h0);

        // single request with seq restored on the way back
        setReq(2, 16'hBEEF, 34'h2_0000_0040, '0);
        up_reqRd = 4'b0100;
        #1;
        chk("beef stall", up_reqStall, 4'b1011);
        tick();
        up_reqRd = '0;
        #1;
        chk("beef tag", dn_reqSeq, 16'd0);
        chk("beef addr", dn_reqAddr, 34'h2_0000_0040);
        rsp(16'd0, 512'hCAFE, 3'd5);
        chk("beef vld", up_rspVld, 4'b0100);
        chk("beef seq", up_rspSeq, 16'hBEEF);
        chk("beef dout", up_rspDout, 512'hCAFE);
        chk("beef attr", up_rspAttr, 3'd5);

        // fill all tags, then one free tag is reused
        up_reqRd = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            setReq(0, 16'h0A00 + 16'(k), 34'h4000 + 34'(k), '0);
            tick();
        end
        #1;
        chk("full cnt", numOutstanding, 5'd16);
        chk("full stall", up_reqStall, 4'hF);
        chk("full last tag", dn_reqSeq, 16'd15);
        tick();
        chk("full no issue", dn_reqRd, 1'b0);
        setReq(0, 16'h0A10, 34'h4100, '0);
        rsp(16'd5, 512'h6005, 3'd1);
        chk("free5 vld", up_rspVld, 4'b0001);
        chk("free5 seq", up_rspSeq, 16'h0A05);
        chk("free5 cnt", numOutstanding, 5'd15);
        chk("free5 stall", up_reqStall, 4'b1110);
        tick();
        up_reqRd = '0;
        #1;
        chk("reuse tag", dn_reqSeq, 16'd5);
        chk("reuse rd", dn_reqRd, 1'b1);
        chk("reuse cnt", numOutstanding, 5'd16);

        // response backpressure, then drain everything
        up_rspStall = 4'b0001;
        rsp(16'd0, 512'h7000, 3'd0);
        chk("bp dnStall", dn_rspStall, 1'b1);
        chk("bp vld", up_rspVld, 4'b0001);
        chk("bp cnt", numOutstanding, 5'd15);
        dn_rspVld = 1'b1;
        dn_rspSeq = 16'd1;
        tick();
        chk("bp held cnt", numOutstanding, 5'd15);
        chk("bp held seq", up_rspSeq, 16'h0A00);
        up_rspStall = '0;
        for (int t = 1; t < 16; t++) begin
            dn_rspSeq = 16'(t);
            dn_rspVld = 1'b1;
            tick();
        end
        dn_rspVld = 1'b0;
        #1;
        chk("drain cnt", numOutstanding, 5'd0);
        chk("drain last seq", up_rspSeq, 16'h0A0F);
        tick();
        chk("drain idle", up_rspVld, 4'h0);

        // downstream stall freezes the request stage
        setReq(0, 16'h0500, 34'h3_0000_0000, '0);
        setReq(1, 16'h0501, 34'h0_0000_0080, '0);
        dn_reqStall = 1'b1;
        up_reqRd = 4'b0011;
        tick();
        chk("dst tag", dn_reqSeq, 16'd0);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("dst stall %0d", c), up_reqStall, 4'hF);
            chk($sformatf("dst rd %0d", c), dn_reqRd, 1'b1);
            chk($sformatf("dst addr %0d", c), dn_reqAddr, 34'h0_0000_0080);
            chk($sformatf("dst cnt %0d", c), numOutstanding, 5'd1);
            tick();
        end
        dn_reqStall = 1'b0;
        #1;
        chk("dst release stall", up_reqStall, 4'b1110);
        tick();
        up_reqRd = '0;
        #1;
        chk("dst next tag", dn_reqSeq, 16'd1);
        chk("dst next addr", dn_reqAddr, 34'h3_0000_0000);
        chk("dst next cnt", numOutstanding, 5'd2);
        tick();
        chk("dst drained", dn_reqRd, 1'b0);

        // bad tags are dropped and flagged
        rsp(16'd9, 512'h9, 3'd0);
        chk("bad9 vld", up_rspVld, 4'h0);
        chk("bad9 err", errBadTag, 1'b1);
        chk("bad9 cnt", numOutstanding, 5'd2);
        rsp(16'h0010, 512'h10, 3'd0);
        chk("bad16 vld", up_rspVld, 4'h0);
        chk("bad16 cnt", numOutstanding, 5'd2);

        // write request, then reset with three tags outstanding
        setReq(3, 16'h7777, 34'h2_AAAA_AAC0, {8{64'h0123456789ABCDEF}});
        up_reqWr = 4'b1000;
        tick();
        up_reqWr = '0;
        #1;
        chk("wr wr", dn_reqWr, 1'b1);
        chk("wr rd", dn_reqRd, 1'b0);
        chk("wr tag", dn_reqSeq, 16'd2);
        chk("wr din", dn_reqDin, {8{64'h0123456789ABCDEF}});
        chk("wr cnt", numOutstanding, 5'd3);
        rst_n = 1'b0;
        #1;
        chk("mid rst cnt", numOutstanding, 5'd0);
        chk("mid rst err", errBadTag, 1'b0);
        chk("mid rst wr", dn_reqWr, 1'b0);
        chk("mid rst din", dn_reqDin, 512'h0);
        chk("mid rst stall", up_reqStall, 4'h0);
        chk("mid rst rspVld", up_rspVld, 4'h0);
        tick();
        rst_n = 1'b1;
        setReq(3, 16'h1234, 34'h0_0000_1000, '0);
        up_reqRd = 4'b1000;
        #1;
        chk("post rst stall", up_reqStall, 4'b0111);
        tick();
        up_reqRd = '0;
        #1;
        chk("post rst tag", dn_reqSeq, 16'd0);
        chk("post rst cnt", numOutstanding, 5'd1);
        rsp(16'd0, 512'h1, 3'd2);
        chk("post rst vld", up_rspVld, 4'b1000);
        chk("post rst seq", up_rspSeq, 16'h1234);
        chk("post rst idle cnt", numOutstanding, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/l2_req_arbiter.md
Name: l2_req_arbiter

Overview:
Shares one downstream L2 slave-side request/response port among NUMREQ upstream L2 requesters. Each cycle it grants one pending request in round-robin order. It replaces the requester's sequence number with a locally allocated tag and routes each response back to its owner with the original sequence restored. It sits between the per-agent L2 request sources and the single L2 cache port, and it supports out-of-order responses.

Parameters:
NUMREQ, 4, number of upstream requesters
BITADDR, 34, address width
BITDATA, 512, line data width
BITSEQN, 16, sequence/tag field width on both sides
XBITATR, 3, response attribute width
NUMTAGS, 16, maximum outstanding downstream requests (power of 2, at most 2^BITSEQN)
BITTAGS, 4, log2(NUMTAGS)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
up_reqRd  in  NUMREQ  per-requester read request
up_reqWr  in  NUMREQ  per-requester write request
up_reqSeq  in  NUMREQ*BITSEQN  per-requester sequence number
up_reqAddr  in  NUMREQ*BITADDR  per-requester address
up_reqDin  in  NUMREQ*BITDATA  per-requester write data
up_reqStall  out  NUMREQ  per-requester backpressure
up_rspVld  out  NUMREQ  one-hot response valid
up_rspSeq  out  BITSEQN  restored original sequence number (shared)
up_rspDout  out  BITDATA  response data (shared)
up_rspAttr  out  XBITATR  response attribute (shared)
up_rspStall  in  NUMREQ  per-requester response backpressure
dn_reqRd  out  1  downstream read
dn_reqWr  out  1  downstream write
dn_reqSeq  out  BITSEQN  allocated tag, zero-extended
dn_reqAddr  out  BITADDR  downstream address
dn_reqDin  out  BITDATA  downstream write data
dn_reqStall  in  1  downstream backpressure
dn_rspVld  in  1  downstream response valid
dn_rspSeq  in  BITSEQN  tag of the response
dn_rspDout  in  BITDATA  response data
dn_rspAttr  in  XBITATR  response attribute
dn_rspStall  out  1  response backpressure to downstream
numOutstanding  out  BITTAGS+1  count of allocated tags
errBadTag  out  1  sticky: a response arrived for an unallocated tag

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: every output is 0. This includes the request stage, the response stage, the free bitmap (all tags free), the round-robin pointer (requester 0 has highest priority), numOutstanding and errBadTag. up_reqStall resets to 0 and is then computed combinationally.
- Transfer rule, both directions: a beat transfers when valid is high and stall is low in the same cycle.
- Requester i is pending when up_reqRd[i] or up_reqWr[i] is high.
  - Rd and Wr both high is illegal. The block treats it as a read and a bench assertion flags it.
- Request stage: a single register drives all dn_* request outputs.
  - It can load when it is empty, or when it is valid and dn_reqStall is low.
- Grant: combinational round-robin over pending requesters, starting at the pointer.
  - A grant issues only when the request stage can load and at least one tag is free.
  - up_reqStall[i] is the inverse of grant[i] (it is also high when i has no request pending).
  - On a grant, the pointer moves to (winner+1) mod NUMREQ. With no grant, the pointer holds.
- Tag allocation: the lowest-index free tag is chosen.
  - The tag table entry stores {owner id, original seq} and the tag's free bit clears.
  - Request latency is 1 cycle from upstream accept to dn_* valid.
- Response stage: a single register holds {owner, seq, dout, attr}.
  - dn_rspStall = stage valid AND up_rspStall[owner] AND the stage is not draining this cycle.
  - The stage loads when it is empty or draining.
  - up_rspVld is one-hot on the owner. up_rspSeq carries the restored original seq.
- Tag freeing: a tag frees when its downstream response is accepted into the response stage.
  - A tag freed in cycle N can be allocated no earlier than cycle N+1.
  - An allocation and a free in the same cycle must both take effect.
- numOutstanding: +1 on allocate, -1 on free, unchanged when both happen in the same cycle.
- Bad tag: a response for a free tag, or for a tag at or above NUMTAGS, is accepted and dropped. It asserts errBadTag until reset.
- Full: all NUMTAGS allocated → all up_reqStall high. Responses still drain.
- Reset mid-operation: all in-flight state is discarded immediately, with no responses replayed.

Decomposition:
- Package l2_arb_pkg: the tag-entry struct {owner id, seq}, a req-beat struct, and a response-beat struct.
- Sub-module l2_rr_arbiter (NUMREQ): request vector, enable and pointer in; one-hot grant and next pointer out.

Test Plan:
1. Requesters 0–3 issue reads continuously, downstream has no stall → grants in order 0,1,2,3,0 on consecutive cycles; dn_reqSeq = 0,1,2,3,4.
2. Requester 2 reads with seq 0xBEEF and gets tag 0; downstream returns tag 0 → up_rspVld=4'b0100 and up_rspSeq=0xBEEF on the next cycle.
3. Requester 0 issues 16 reads with no responses → numOutstanding=16 and up_reqStall[0]=1; after one response for tag 5 → the next grant is allocated tag 5.
4. Responses come back in tag order 3,1,2 → each is routed to its own owner with the correct seq; numOutstanding decrements to 0.
5. dn_reqStall held for 5 cycles while 2 requesters are pending → dn_* outputs stay stable, up_reqStall stays high, and no tags are allocated.
6. dn_rspVld arrives with unallocated tag 9 → no up_rspVld, errBadTag=1. Then rst_n is pulsed with 3 tags outstanding → numOutstanding=0 and all outputs are 0.
